// File: rtl/param_bank_loader_pkg.sv
// Shared definitions for the parameter bank loader:
// FSM state encoding and a constant clog2 helper.
package param_bank_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        LOAD,
        WR_REQ,
        FINISH,
        FAIL
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/param_bank_loader_timeout.sv
// Ack wait counter: counts cycles spent waiting in a request
// and flags the last allowed cycle without an ack.
module ack_timeout_timer
    import param_bank_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Count while waiting; restart whenever no request is pending.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/param_bank_loader.sv
// Copies a bank of parameter words between external storage and
// parameter cells, one request/ack handshake per word.
module param_bank_loader
    import param_bank_loader_pkg::*;
#(
    parameter int PARAM_NUM      = 8,
    parameter int PARAM_WIDTH    = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_load,
    input  logic                             start_save,
    input  logic [PARAM_NUM*PARAM_WIDTH-1:0] param_values,
    output logic                             mem_rd_req,
    output logic [ADDR_WIDTH-1:0]            mem_rd_addr,
    input  logic                             mem_rd_ack,
    input  logic [PARAM_WIDTH-1:0]           mem_rd_data,
    output logic                             mem_wr_req,
    output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
    output logic [PARAM_WIDTH-1:0]           mem_wr_data,
    input  logic                             mem_wr_ack,
    output logic [PARAM_NUM-1:0]             load_valid,
    output logic [PARAM_WIDTH-1:0]           load_data,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    localparam int IW = clog2(PARAM_NUM) + 1;
    localparam int SW = PARAM_NUM * PARAM_WIDTH;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [PARAM_WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]          snap_q, snap_d;
    logic                   gap_q, gap_d;

    logic                   rd_act;
    logic                   wr_act;
    logic                   req_act;
    logic                   expired;
    logic                   last;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [PARAM_WIDTH-1:0] snap_word;

    // gap_q holds write req low for the cycle after each ack.
    assign rd_act  = (state_q == RD_REQ);
    assign wr_act  = (state_q == WR_REQ) && !gap_q;
    assign req_act = rd_act || wr_act;
    assign last    = (idx_q == IW'(PARAM_NUM - 1));
    assign addr    = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);

    // Select the snapshot word for the current index.
    always_comb begin
        snap_word = '0;
        for (int i = 0; i < PARAM_NUM; i++) begin
            if (idx_q == IW'(i)) begin
                snap_word = snap_q[i*PARAM_WIDTH +: PARAM_WIDTH];
            end
        end
    end

    ack_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!req_act),
        .enable (req_act),
        .expired(expired)
    );

    // State, index, captured word and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            snap_q  <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            snap_q  <= snap_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic; acks take priority over timeout expiry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        snap_d  = snap_q;
        gap_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_load) begin
                    idx_d   = '0;
                    state_d = RD_REQ;
                end else if (start_save) begin
                    idx_d   = '0;
                    snap_d  = param_values;
                    state_d = WR_REQ;
                end
            end
            RD_REQ: begin
                if (mem_rd_ack) begin
                    data_d  = mem_rd_data;
                    state_d = LOAD;
                end else if (expired) begin
                    state_d = FAIL;
                end
            end
            LOAD: begin
                if (last) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RD_REQ;
                end
            end
            WR_REQ: begin
                if (gap_q) begin
                    state_d = WR_REQ;
                end else if (mem_wr_ack) begin
                    if (last) begin
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        gap_d = 1'b1;
                    end
                end else if (expired) begin
                    state_d = FAIL;
                end
            end
            FINISH:  state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from state only, so reset forces them all to 0.
    always_comb begin
        mem_rd_req  = rd_act;
        mem_rd_addr = rd_act ? addr : '0;
        mem_wr_req  = wr_act;
        mem_wr_addr = wr_act ? addr : '0;
        mem_wr_data = wr_act ? snap_word : '0;
        load_data   = (state_q == LOAD) ? data_q : '0;
        busy        = (state_q == RD_REQ) || (state_q == LOAD) ||
                      (state_q == WR_REQ);
        done        = (state_q == FINISH);
        error       = (state_q == FAIL);
        load_valid  = '0;
        for (int i = 0; i < PARAM_NUM; i++) begin
            load_valid[i] = (state_q == LOAD) && (idx_q == IW'(i));
        end
    end

endmodule

// File: tb/tb_param_bank_loader.sv
// Bench for param_bank_loader: per-transaction expected traces built
// from the latency rules, compared against the DUT every cycle.
module tb_param_bank_loader;

    localparam int PN   = 4;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int BASE = 14;
    localparam int TO   = 15;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_load;
    logic            start_save;
    logic [PN*DW-1:0] param_values;
    logic            mem_rd_req;
    logic [AW-1:0]   mem_rd_addr;
    logic            mem_rd_ack;
    logic [DW-1:0]   mem_rd_data;
    logic            mem_wr_req;
    logic [AW-1:0]   mem_wr_addr;
    logic [DW-1:0]   mem_wr_data;
    logic            mem_wr_ack;
    logic [PN-1:0]   load_valid;
    logic [DW-1:0]   load_data;
    logic            busy;
    logic            done;
    logic            error;

    always #5 clk = ~clk;

    param_bank_loader #(
        .PARAM_NUM     (PN),
        .PARAM_WIDTH   (DW),
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (BASE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_load  (start_load),
        .start_save  (start_save),
        .param_values(param_values),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_data (mem_rd_data),
        .mem_wr_req  (mem_wr_req),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ack  (mem_wr_ack),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    typedef struct packed {
        logic          rreq;
        logic [AW-1:0] raddr;
        logic          wreq;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [PN-1:0] lv;
        logic [DW-1:0] ld;
        logic          busy;
        logic          done;
        logic          err;
    } obs_t;

    typedef struct {
        logic          sl;
        logic          ss;
        logic [31:0]   pv;
        logic          rack;
        logic          wack;
        logic [DW-1:0] rdata;
        obs_t          o;
    } ent_t;

    ent_t         q[$];
    logic [DW-1:0] mem[16];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int obs_ld[$];
    int obs_rd[$];
    int obs_wr[$];
    int n_rreq = 0;
    int n_done = 0;
    int n_err  = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.rreq  = mem_rd_req;
        o.raddr = mem_rd_addr;
        o.wreq  = mem_wr_req;
        o.waddr = mem_wr_addr;
        o.wdata = mem_wr_data;
        o.lv    = load_valid;
        o.ld    = load_data;
        o.busy  = busy;
        o.done  = done;
        o.err   = error;
        return o;
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h",
                     nm, cyc, got, exp);
        end
    endtask

    task automatic chk4(string nm, input int got[$],
                        input int e0, input int e1,
                        input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        chk({nm, "_count"}, 64'(got.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk(nm, (i < got.size()) ? 64'(got[i]) : 64'hdead,
                64'(ex[i]));
        end
    endtask

    function automatic ent_t idle_e();
        ent_t e;
        e.sl    = 1'b0;
        e.ss    = 1'b0;
        e.pv    = $urandom;
        e.rack  = ($urandom_range(0, 3) == 0);
        e.wack  = ($urandom_range(0, 3) == 0);
        e.rdata = 8'($urandom);
        e.o     = '0;
        return e;
    endfunction

    // Starts issued while busy must be ignored.
    function automatic ent_t busy_e();
        ent_t e;
        e = idle_e();
        if ($urandom_range(0, 5) == 0) begin
            e.sl = 1'($urandom_range(0, 1));
            e.ss = 1'($urandom_range(0, 1));
        end
        e.o.busy = 1'b1;
        return e;
    endfunction

    // Ack latency; 14 is the last cycle still inside the limit,
    // 99 means the ack never arrives.
    function automatic int pick_lat();
        int r;
        r = $urandom_range(0, 39);
        if (r < 34) return r % 5;
        if (r < 37) return TO - 1;
        return 99;
    endfunction

    // Expected trace: start cycle, per word (lat+1) request cycles
    // then a load strobe (load) or a one-cycle gap (save, not last),
    // finally a done pulse; or TO request cycles then an error pulse.
    task automatic gen(bit is_load, bit both, int fixed_lat,
                       logic [31:0] snap);
        ent_t       e;
        int         lat;
        int         n;
        bit         tmo;
        logic [3:0] a;
        e    = idle_e();
        e.sl = is_load;
        e.ss = !is_load || both;
        if (!is_load) e.pv = snap;
        q.push_back(e);
        for (int k = 0; k < PN; k++) begin
            lat = (fixed_lat >= 0) ? fixed_lat : pick_lat();
            tmo = (lat >= TO);
            n   = tmo ? TO : lat + 1;
            a   = 4'((BASE + k) % 16);
            for (int j = 0; j < n; j++) begin
                e = busy_e();
                if (is_load) begin
                    e.o.rreq  = 1'b1;
                    e.o.raddr = a;
                    e.rack    = !tmo && (j == n - 1);
                    if (e.rack) e.rdata = mem[a];
                end else begin
                    e.o.wreq  = 1'b1;
                    e.o.waddr = a;
                    e.o.wdata = snap[k*DW +: DW];
                    e.wack    = !tmo && (j == n - 1);
                end
                q.push_back(e);
            end
            if (tmo) begin
                e       = idle_e();
                e.o.err = 1'b1;
                q.push_back(e);
                return;
            end
            if (is_load) begin
                e      = busy_e();
                e.o.lv = 4'(1 << k);
                e.o.ld = mem[a];
                q.push_back(e);
            end else if (k < PN - 1) begin
                q.push_back(busy_e());
            end
        end
        e        = idle_e();
        e.o.done = 1'b1;
        q.push_back(e);
    endtask

    task automatic step(ent_t e);
        obs_t o;
        @(negedge clk);
        cyc++;
        o = dut_obs();
        chk("cycle_outputs", 64'(o), 64'(e.o));
        if (o.lv != '0) obs_ld.push_back(int'({o.lv, o.ld}));
        if (o.rreq) n_rreq++;
        if (o.rreq && e.rack) obs_rd.push_back(int'(o.raddr));
        if (o.wreq && e.wack) obs_wr.push_back(int'({o.waddr, o.wdata}));
        if (o.done) n_done++;
        if (o.err) n_err++;
        start_load   = e.sl;
        start_save   = e.ss;
        param_values = e.pv;
        mem_rd_ack   = e.rack;
        mem_rd_data  = e.rdata;
        mem_wr_ack   = e.wack;
    endtask

    task automatic run_q();
        while (q.size() > 0) step(q.pop_front());
    endtask

    task automatic idle_n(int n);
        repeat (n) step(idle_e());
    endtask

    task automatic clr_obs();
        obs_ld.delete();
        obs_rd.delete();
        obs_wr.delete();
        n_rreq = 0;
        n_done = 0;
        n_err  = 0;
    endtask

    function automatic int q_rreq_cnt();
        int c;
        c = 0;
        foreach (q[i]) if (q[i].o.rreq) c++;
        return c;
    endfunction

    initial begin
        obs_t pre;
        int   r;
        rst          = 1'b1;
        start_load   = 1'b0;
        start_save   = 1'b0;
        param_values = '0;
        mem_rd_ack   = 1'b0;
        mem_rd_data  = '0;
        mem_wr_ack   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

        // Reset state.
        idle_n(2);
        chk("reset_outputs", 64'(dut_obs()), 64'd0);
        rst = 1'b0;
        idle_n(2);

        // Directed load, ack latency 3, wrap 14,15,0,1.
        mem[14] = 8'd5;
        mem[15] = 8'd7;
        mem[0]  = 8'd0;
        mem[1]  = 8'd255;
        clr_obs();
        gen(1'b1, 1'b0, 3, 32'd0);
        chk("model_load_len", 64'(q.size()), 64'd22);
        chk("model_first_req", 64'(q[1].o.rreq), 64'd1);
        run_q();
        chk4("load_strobes", obs_ld, 'h105, 'h207, 'h400, 'h8ff);
        chk4("read_addrs", obs_rd, 14, 15, 0, 1);
        chk("load_done", 64'(n_done), 64'd1);
        idle_n(2);

        // Directed save from the snapshot.
        clr_obs();
        gen(1'b0, 1'b0, 1, 32'h09080706);
        run_q();
        chk4("save_writes", obs_wr, 'he06, 'hf07, 'h008, 'h109);
        chk("save_done", 64'(n_done), 64'd1);
        idle_n(1);

        // Read ack never arrives.
        clr_obs();
        gen(1'b1, 1'b0, 99, 32'd0);
        chk("model_tmo_reqs", 64'(q_rreq_cnt()), 64'd15);
        run_q();
        chk("tmo_req_cycles", 64'(n_rreq), 64'd15);
        chk("tmo_error", 64'(n_err), 64'd1);
        chk("tmo_no_load", 64'(obs_ld.size()), 64'd0);
        chk("tmo_no_done", 64'(n_done), 64'd0);
        idle_n(2);

        // Both starts together, plus a save start while busy.
        clr_obs();
        gen(1'b1, 1'b1, 2, $urandom);
        q[3].ss = 1'b1;
        run_q();
        chk("both_no_writes", 64'(obs_wr.size()), 64'd0);
        chk("both_loads", 64'(obs_ld.size()), 64'd4);
        idle_n(1);

        // Reset during the third read.
        clr_obs();
        gen(1'b1, 1'b0, 2, 32'd0);
        repeat (10) step(q.pop_front());
        pre = dut_obs();
        chk("rd3_active", 64'({pre.rreq, pre.raddr}), 64'h10);
        rst = 1'b1;
        #1;
        chk("rst_abort_outputs", 64'(dut_obs()), 64'd0);
        q.delete();
        idle_n(2);
        rst = 1'b0;
        idle_n(3);
        chk("rst_no_pulse", 64'(n_done + n_err), 64'd0);
        clr_obs();
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        gen(1'b1, 1'b0, 1, 32'd0);
        run_q();
        chk4("post_rst_reads", obs_rd, 14, 15, 0, 1);
        chk("post_rst_done", 64'(n_done), 64'd1);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            end
            r = $urandom_range(0, 2);
            gen(r != 1, r == 2, -1, $urandom);
            run_q();
            idle_n($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
